// File: rtl/dual_port_ram_scheduler_pkg.sv
// Shared types, defaults and helpers for dual_port_ram_scheduler.
// Packed-slice macro DPRS_SLICE selects element i of width w.
`ifndef DUAL_PORT_RAM_SCHEDULER_PKG_SV
`define DUAL_PORT_RAM_SCHEDULER_PKG_SV

`define DPRS_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package dual_port_ram_scheduler_pkg;

  localparam int DefDataWidth    = 8;
  localparam int DefAddressWidth = 4;
  localparam int DefNumReq       = 4;
  localparam int MaxIdxW         = 4;

  typedef struct packed {
    logic               valid;
    logic [MaxIdxW-1:0] idx;
  } owner_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/dual_port_ram_scheduler_picker.sv
// rr_two_grant_picker: round-robin search yielding up to two grants.
// Port 1 takes the next valid requester after the port 0 winner.
module rr_two_grant_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  reqValid,
  input  logic [IW-1:0] rrPtr,
  input  logic [N-1:0]  p1Mask,
  output logic [N-1:0]  grant0,
  output logic [N-1:0]  grant1,
  output logic [IW-1:0] idx0,
  output logic [IW-1:0] idx1,
  output logic          any0,
  output logic          any1
);

  logic [IW-1:0] k;

  always_comb begin
    grant0 = '0;
    grant1 = '0;
    idx0   = '0;
    idx1   = '0;
    any0   = 1'b0;
    any1   = 1'b0;
    k      = '0;
    for (int off = 0; off < N; off++) begin
      k = IW'((int'(rrPtr) + off) % N);
      if (reqValid[k]) begin
        if (!any0) begin
          any0 = 1'b1;
          idx0 = k;
        end else if (!any1 && p1Mask[k]) begin
          any1 = 1'b1;
          idx1 = k;
        end
      end
    end
    grant0[idx0] = any0;
    grant1[idx1] = any1;
  end

endmodule

// File: rtl/dual_port_ram_scheduler.sv
// Two-port round-robin front end for simple_dual_port_ram.
// WRITE_COLLISION_STALL_EN serializes same-address write pairs.
module dual_port_ram_scheduler
  import dual_port_ram_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = DefDataWidth,
  parameter int ADDRESS_WIDTH = DefAddressWidth,
  parameter int NUM_REQ       = DefNumReq
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data,
  output logic                             writeEnable_0,
  output logic                             writeEnable_1,
  output logic [DATA_WIDTH-1:0]            writeData_0,
  output logic [DATA_WIDTH-1:0]            writeData_1,
  output logic [ADDRESS_WIDTH-1:0]         address_0,
  output logic [ADDRESS_WIDTH-1:0]         address_1,
  input  logic [DATA_WIDTH-1:0]            readData_0,
  input  logic [DATA_WIDTH-1:0]            readData_1
);

  localparam int IW = clog2(NUM_REQ);

  logic [IW-1:0]            rrPtr;
  logic [IW-1:0]            ptrNext;
  logic [NUM_REQ-1:0]       g0;
  logic [NUM_REQ-1:0]       g1;
  logic [NUM_REQ-1:0]       p1Mask;
  logic [IW-1:0]            idx0;
  logic [IW-1:0]            idx1;
  logic                     any0;
  logic                     any1;
  logic                     stall;
  logic                     take0;
  logic                     take1;
  logic [ADDRESS_WIDTH-1:0] a0;
  logic [ADDRESS_WIDTH-1:0] a1;
  logic [DATA_WIDTH-1:0]    d0;
  logic [DATA_WIDTH-1:0]    d1;
  owner_t                   own0;
  owner_t                   own1;

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] i);
    return IW'((int'(i) + 1) % NUM_REQ);
  endfunction

  assign p1Mask = '1;

  rr_two_grant_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) picker (
    .reqValid (req_valid),
    .rrPtr    (rrPtr),
    .p1Mask   (p1Mask),
    .grant0   (g0),
    .grant1   (g1),
    .idx0     (idx0),
    .idx1     (idx1),
    .any0     (any0),
    .any1     (any1)
  );

  assign a0 = `DPRS_SLICE(req_address, idx0, ADDRESS_WIDTH);
  assign a1 = `DPRS_SLICE(req_address, idx1, ADDRESS_WIDTH);
  assign d0 = `DPRS_SLICE(req_data, idx0, DATA_WIDTH);
  assign d1 = `DPRS_SLICE(req_data, idx1, DATA_WIDTH);

`ifdef WRITE_COLLISION_STALL_EN
  // Withheld requester becomes the port 0 winner next cycle
  assign stall = any1 && req_write[idx0]
              && req_write[idx1] && (a0 == a1);
`else
  assign stall = 1'b0;
`endif

  assign take0 = any0 && !reset;
  assign take1 = any1 && !stall && !reset;

  assign req_ready = (take0 ? g0 : '0) | (take1 ? g1 : '0);

  assign writeEnable_0 = take0 && req_write[idx0];
  assign writeEnable_1 = take1 && req_write[idx1];
  assign address_0     = take0 ? a0 : '0;
  assign address_1     = take1 ? a1 : '0;
  assign writeData_0   = take0 ? d0 : '0;
  assign writeData_1   = take1 ? d1 : '0;

  always_comb begin
    ptrNext = rrPtr;
    if (take1) ptrNext = bump(idx1);
    else if (take0) ptrNext = bump(idx0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr <= '0;
      own0  <= '0;
      own1  <= '0;
    end else begin
      rrPtr     <= ptrNext;
      own0.valid <= take0;
      own0.idx   <= MaxIdxW'(idx0);
      own1.valid <= take1;
      own1.idx   <= MaxIdxW'(idx1);
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own0.valid && own0.idx == MaxIdxW'(i)) begin
        resp_valid[i] = 1'b1;
        `DPRS_SLICE(resp_data, i, DATA_WIDTH) = readData_0;
      end
      if (own1.valid && own1.idx == MaxIdxW'(i)) begin
        resp_valid[i] = 1'b1;
        `DPRS_SLICE(resp_data, i, DATA_WIDTH) = readData_1;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_scheduler.sv
// Scoreboard bench for dual_port_ram_scheduler with a behavioural
// write-first dual-port RAM (port 1 wins same-address write pairs).
module tb_dual_port_ram_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [15:0] req_address;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [31:0] resp_data;
  logic        writeEnable_0;
  logic        writeEnable_1;
  logic [7:0]  writeData_0;
  logic [7:0]  writeData_1;
  logic [3:0]  address_0;
  logic [3:0]  address_1;
  logic [7:0]  readData_0;
  logic [7:0]  readData_1;
  logic        preload;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  logic [7:0] mem [16];

  dual_port_ram_scheduler #(
    .DATA_WIDTH    (8),
    .ADDRESS_WIDTH (4),
    .NUM_REQ       (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_address   (req_address),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .writeEnable_0 (writeEnable_0),
    .writeEnable_1 (writeEnable_1),
    .writeData_0   (writeData_0),
    .writeData_1   (writeData_1),
    .address_0     (address_0),
    .address_1     (address_1),
    .readData_0    (readData_0),
    .readData_1    (readData_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
    end else begin
      if (writeEnable_0) mem[address_0] <= writeData_0;
      if (writeEnable_1) mem[address_1] <= writeData_1;
    end
    if (writeEnable_0 && writeEnable_1 && address_0 == address_1)
      readData_0 <= writeData_1;
    else
      readData_0 <= writeEnable_0 ? writeData_0 : mem[address_0];
    readData_1 <= writeEnable_1 ? writeData_1 : mem[address_1];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  always @(negedge clock) begin
    logic [31:0] m;
    exp_t e;
    if (!reset) begin
      m = '0;
      for (int i = 0; i < 4; i++) begin
        m[i*8 +: 8] = {8{resp_valid[i]}};
        if (resp_valid[i]) begin
          if (q.size() == 0) begin
            chk("resp_unexpected", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("resp_idx", 32'(i), 32'(e.idx));
            chk("resp_data", 32'(resp_data[i*8 +: 8]), 32'(e.data));
          end
        end
      end
      chk("resp_idle_zero", resp_data & ~m, 32'h0);
    end
  end

  task automatic drive(input logic [3:0] v, input logic [3:0] w,
                       input logic [15:0] a, input logic [31:0] d);
    req_valid   = v;
    req_write   = w;
    req_address = a;
    req_data    = d;
  endtask

  task automatic issue(input string nm, input logic [3:0] v,
                       input logic [3:0] w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] rdy);
    drive(v, w, a, d);
    @(negedge clock);
    chk({nm, "_ready"}, 32'(req_ready), 32'(rdy));
  endtask

  task automatic retire(input logic [3:0] rm, input logic [31:0] rd);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      if (rm[i]) q.push_back('{idx: i, data: rd[i*8 +: 8]});
    end
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    preload = 1'b1;
    drive(4'b1111, 4'b1111, 16'hFFFF, 32'hFFFF_FFFF);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", {writeEnable_1, writeEnable_0}, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_ptr", 32'(dut.rrPtr), 32'h0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    preload = 1'b0;
    drive(4'b0, 4'b0, 16'h0, 32'h0);
    @(posedge clock);
    #1;

    issue("t1", 4'b0100, 4'b0100, {4'd0, 4'd14, 4'd0, 4'd0},
          32'h0049_0000, 4'b0100);
    chk("t1_we0", 32'(writeEnable_0), 32'h1);
    chk("t1_addr0", 32'(address_0), 32'd14);
    chk("t1_wd0", 32'(writeData_0), 32'h49);
    chk("t1_we1", 32'(writeEnable_1), 32'h0);
    retire(4'b0100, 32'h0049_0000);

    issue("t1b", 4'b1000, 4'b1000, {4'd7, 12'd0},
          32'h5300_0000, 4'b1000);
    retire(4'b1000, 32'h5300_0000);
    chk("t1b_ptr", 32'(dut.rrPtr), 32'h0);

    issue("t2", 4'b1001, 4'b0000, {4'd7, 4'd0, 4'd0, 4'd14},
          32'h0, 4'b1001);
    chk("t2_addr0", 32'(address_0), 32'd14);
    chk("t2_addr1", 32'(address_1), 32'd7);
    chk("t2_we", {writeEnable_1, writeEnable_0}, 32'h0);
    retire(4'b1001, 32'h5300_0049);
    chk("t2_ptr", 32'(dut.rrPtr), 32'h0);

    for (int c = 0; c < 4; c++) begin
      logic [3:0] r;
      r = c[0] ? 4'b1100 : 4'b0011;
      issue("t3", 4'b1111, 4'b0000, {4'd3, 4'd2, 4'd1, 4'd0},
            32'h0, r);
      retire(r, 32'hA3A2_A1A0);
    end

`ifdef WRITE_COLLISION_STALL_EN
    issue("t4a", 4'b0110, 4'b0110, {4'd0, 4'd7, 4'd7, 4'd0},
          32'h0022_1100, 4'b0010);
    retire(4'b0010, 32'h0000_1100);
    issue("t4b", 4'b0100, 4'b0100, {4'd0, 4'd7, 4'd7, 4'd0},
          32'h0022_1100, 4'b0100);
    retire(4'b0100, 32'h0022_0000);
`else
    issue("t4", 4'b0110, 4'b0110, {4'd0, 4'd7, 4'd7, 4'd0},
          32'h0022_1100, 4'b0110);
    retire(4'b0110, 32'h0022_2200);
`endif
    drive(4'b0, 4'b0, 16'h0, 32'h0);
    @(posedge clock);
    #1;
    chk("t4_mem7", 32'(mem[7]), 32'h22);
    issue("t4_rd", 4'b0001, 4'b0000, {12'd0, 4'd7}, 32'h0, 4'b0001);
    retire(4'b0001, 32'h0000_0022);

    issue("t5", 4'b1000, 4'b0000, 16'h0, 32'h0, 4'b1000);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(4'b1111, 4'b1111, 16'h7777, 32'h5555_5555);
    @(negedge clock);
    chk("t5_resp_valid", 32'(resp_valid), 32'h0);
    chk("t5_resp_data", resp_data, 32'h0);
    chk("t5_ready", 32'(req_ready), 32'h0);
    chk("t5_we", {writeEnable_1, writeEnable_0}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("t5_ptr", 32'(dut.rrPtr), 32'h0);
    issue("t5_after", 4'b0110, 4'b0000, {4'd0, 4'd14, 4'd2, 4'd0},
          32'h0, 4'b0110);
    retire(4'b0110, 32'h0049_A200);

    drive(4'b0, 4'b0, 16'h0, 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("queue_empty", 32'(q.size()), 32'h0);
    chk("mem7_final", 32'(mem[7]), 32'h22);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
